// File: rtl/chance_pkg.sv
// Shared types and constants for the stop/answer game (player and scorer).
package chance_pkg;

  typedef enum logic [1:0] {IDLE, GAP, PULSE, DONE} state_e;

  // x^16 + x^14 + x^13 + x^11 + 1, bit 15 is the x^16 term.
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

  // Counter and sum widths must match the scorer.
  localparam int CNT_W = 4;
  localparam int SUM_W = 7;

  // One Fibonacci step: shift left, XOR of tapped bits enters bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/chance_lfsr16.sv
// 16-bit Fibonacci LFSR with load, enable and zero-seed substitution.
module chance_lfsr16
  import chance_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        en,
  input  logic [15:0] load_val,
  output logic [15:0] q
);

  logic [15:0] q_q;

  // Load wins over stepping; an all-zero seed would lock up, so swap in SEED.
  always_ff @(posedge clk) begin
    if (reset)     q_q <= SEED;
    else if (load) q_q <= (load_val == 16'd0) ? SEED : load_val;
    else if (en)   q_q <= lfsr_step(q_q);
  end

  assign q = q_q;

endmodule

// File: rtl/chance_player.sv
// Player side of the stop/answer game: emits stop pulses at LFSR-random
// intervals, mirrors the scorer's counter and predicts the scorer's answer.
module chance_player
  import chance_pkg::*;
#(
  parameter int          ROUNDS        = 3,
  parameter int          MIN_GAP       = 2,
  parameter int          GAP_RAND_BITS = 4,
  parameter int          PULSE_W       = 1,
  parameter logic [15:0] LFSR_SEED     = LFSR_SEED_DEF,
  parameter int          CNT_W         = chance_pkg::CNT_W,
  parameter int          SUM_W         = chance_pkg::SUM_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             seed_load,
  input  logic [15:0]      seed,
  output logic             stop,
  output logic             busy,
  output logic             done,
  output logic [SUM_W-1:0] expected,
  output logic [3:0]       round_idx
);

  localparam logic [15:0] GAP_MASK  = 16'((32'd1 << GAP_RAND_BITS) - 32'd1);
  localparam logic [15:0] MIN_GAP_V = 16'(MIN_GAP);
  localparam logic [15:0] PW_LAST   = 16'(PULSE_W - 1);
  localparam logic [3:0]  ROUNDS_V  = 4'(ROUNDS);

  state_e             state_q, state_d;
  logic [15:0]        gap_q, gap_d;
  logic [15:0]        pcnt_q, pcnt_d;
  logic [CNT_W-1:0]   m_q, m_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [SUM_W-1:0]   exp_q, exp_d;
  logic [3:0]         ridx_q, ridx_d;
  logic               stop_q, done_q, done_d;
  logic [15:0]        lfsr;
  logic [15:0]        gap_new;
  logic               in_idle;

  assign in_idle = (state_q == IDLE);

  // LFSR only moves during a game so the gap sequence depends on the seed alone.
  chance_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .load     (in_idle && seed_load),
    .en       (!in_idle),
    .load_val (seed),
    .q        (lfsr)
  );

  assign gap_new = MIN_GAP_V + (lfsr & GAP_MASK);

  // Next-state logic for the game sequencer, mirror counter and running sum.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    pcnt_d  = pcnt_q;
    m_d     = m_q;
    sum_d   = sum_q;
    exp_d   = exp_q;
    ridx_d  = ridx_q;
    done_d  = 1'b0;
    // Scorer counts only while stop is low; stop_q is exactly what it sees.
    if (!in_idle) m_d = stop_q ? m_q : m_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (!seed_load && start) begin
          m_d     = '0;
          sum_d   = '0;
          ridx_d  = '0;
          exp_d   = '0;
          gap_d   = gap_new;
          state_d = GAP;
        end
      end
      GAP: begin
        gap_d = gap_q - 16'd1;
        if (gap_q == 16'd1) begin
          pcnt_d  = '0;
          state_d = PULSE;
        end
      end
      PULSE: begin
        pcnt_d = pcnt_q + 16'd1;
        // Scorer samples on the rising edge, so only the first cycle adds.
        if (pcnt_q == 16'd0) sum_d = sum_q + SUM_W'(m_q);
        if (pcnt_q == PW_LAST) begin
          ridx_d = ridx_q + 4'd1;
          if (ridx_q + 4'd1 == ROUNDS_V) begin
            state_d = DONE;
          end else begin
            gap_d   = gap_new;
            state_d = GAP;
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        exp_d   = sum_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; stop is registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gap_q   <= '0;
      pcnt_q  <= '0;
      m_q     <= '0;
      sum_q   <= '0;
      exp_q   <= '0;
      ridx_q  <= '0;
      stop_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      pcnt_q  <= pcnt_d;
      m_q     <= m_d;
      sum_q   <= sum_d;
      exp_q   <= exp_d;
      ridx_q  <= ridx_d;
      stop_q  <= (state_d == PULSE);
      done_q  <= done_d;
    end
  end

  assign stop      = stop_q;
  assign busy      = !in_idle;
  assign done      = done_q;
  assign expected  = exp_q;
  assign round_idx = ridx_q;

endmodule

// File: tb/tb_chance_player.sv
// Bench for chance_player: four configurations, a cycle-level schedule model
// built from the game rules, and a behavioural scorer watching stop.
module tb_chance_player;

  logic        clk = 1'b0;
  logic        reset;
  logic        seed_load;
  logic [15:0] seed;
  logic [3:0]  start;
  logic [3:0]  stop_w, busy_w, done_w;
  logic [6:0]  exp_w  [4];
  logic [3:0]  ridx_w [4];

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  chance_player dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .seed_load(seed_load), .seed(seed),
    .stop(stop_w[0]), .busy(busy_w[0]), .done(done_w[0]), .expected(exp_w[0]), .round_idx(ridx_w[0]));
  chance_player #(.ROUNDS(3), .MIN_GAP(5), .GAP_RAND_BITS(0), .PULSE_W(1)) dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .seed_load(seed_load), .seed(seed),
    .stop(stop_w[1]), .busy(busy_w[1]), .done(done_w[1]), .expected(exp_w[1]), .round_idx(ridx_w[1]));
  chance_player #(.ROUNDS(3), .MIN_GAP(7), .GAP_RAND_BITS(0), .PULSE_W(2)) dut2 (
    .clk(clk), .reset(reset), .start(start[2]), .seed_load(seed_load), .seed(seed),
    .stop(stop_w[2]), .busy(busy_w[2]), .done(done_w[2]), .expected(exp_w[2]), .round_idx(ridx_w[2]));
  chance_player #(.ROUNDS(4), .MIN_GAP(10), .GAP_RAND_BITS(0), .PULSE_W(1)) dut3 (
    .clk(clk), .reset(reset), .start(start[3]), .seed_load(seed_load), .seed(seed),
    .stop(stop_w[3]), .busy(busy_w[3]), .done(done_w[3]), .expected(exp_w[3]), .round_idx(ridx_w[3]));

  function automatic int p_min(input int i);
    case (i) 0: return 2; 1: return 5; 2: return 7; default: return 10; endcase
  endfunction
  function automatic int p_rounds(input int i);
    return (i == 3) ? 4 : 3;
  endfunction
  function automatic int p_rb(input int i);
    return (i == 0) ? 4 : 0;
  endfunction
  function automatic int p_pw(input int i);
    return (i == 2) ? 2 : 1;
  endfunction

  // x^16+x^14+x^13+x^11+1 stepped n times.
  function automatic logic [15:0] adv(input logic [15:0] v, input int n);
    logic [15:0] x;
    x = v;
    for (int i = 0; i < n; i++) x = {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    return x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    ntests++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  // Play one game on DUT idx whose LFSR holds l0; optionally poke start mid-game.
  task automatic run_game(input int idx, input logic [15:0] l0, input bit poke,
                          output logic [15:0] l_end, output int t_obs);
    bit          q_stop[$];
    int          q_ridx[$];
    int          e, sum_g, exp_sum, g, mask, tt, sc_cnt, sc_sum, lowrun;
    bit          prev;
    logic [15:0] v;
    mask = (1 << p_rb(idx)) - 1;
    e = 0; sum_g = 0; exp_sum = 0;
    for (int r = 0; r < p_rounds(idx); r++) begin
      // Gap for the first round uses the frozen seed; later ones the LFSR
      // value present in the last pulse cycle (it steps once per busy cycle).
      v = (r == 0) ? l0 : adv(l0, e - 1);
      g = p_min(idx) + int'(v & 16'(mask));
      sum_g   += g;
      exp_sum  = (exp_sum + (sum_g % 16)) % 128;
      for (int j = 0; j < g; j++)          begin q_stop.push_back(1'b0); q_ridx.push_back(r); end
      for (int j = 0; j < p_pw(idx); j++)  begin q_stop.push_back(1'b1); q_ridx.push_back(r); end
      e += g + p_pw(idx);
    end
    q_stop.push_back(1'b0); q_ridx.push_back(p_rounds(idx));
    tt = e + 1;
    sc_cnt = 0; sc_sum = 0; lowrun = 0; prev = 1'b0; t_obs = -1;

    @(negedge clk); start[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k <= tt; k++) begin
      if (k > 0) @(negedge clk);
      if (done_w[idx] && t_obs < 0) t_obs = k;
      if (k < tt) begin
        chk("stop", stop_w[idx], q_stop[k]);
        chk("busy", busy_w[idx], 1);
        chk("done_early", done_w[idx], 0);
        chk("round_idx", ridx_w[idx], q_ridx[k]);
        // Behavioural scorer: counts while stop low, samples on the rise.
        if (stop_w[idx] && !prev) begin
          sc_sum = (sc_sum + sc_cnt) % 128;
          chk("gap_range", (lowrun >= p_min(idx)) && (lowrun <= p_min(idx) + mask), 1);
          lowrun = 0;
        end
        if (!stop_w[idx]) begin
          sc_cnt = (sc_cnt + 1) % 16;
          lowrun++;
        end
        prev = stop_w[idx];
      end else begin
        chk("done", done_w[idx], 1);
        chk("busy_end", busy_w[idx], 0);
        chk("stop_end", stop_w[idx], 0);
        chk("expected", exp_w[idx], exp_sum);
        chk("scorer_vs_expected", exp_w[idx], sc_sum);
        chk("round_idx_end", ridx_w[idx], p_rounds(idx));
      end
      start[idx] = poke && (k == 3 || k == tt - 1);
    end
    start[idx] = 1'b0;
    l_end = adv(l0, tt);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] l0, le, s;
    int          t, dcnt;
    reset = 1'b1; start = '0; seed_load = 1'b0; seed = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("rst_stop", stop_w[i], 0);
      chk("rst_busy", busy_w[i], 0);
      chk("rst_done", done_w[i], 0);
      chk("rst_expected", exp_w[i], 0);
      chk("rst_round_idx", ridx_w[i], 0);
    end
    chk("rst_lfsr", dut0.lfsr, 16'hACE1);

    // Fixed-gap configurations with hand-derived answers.
    run_game(1, 16'hACE1, 1'b0, le, t);
    chk("g1_expected", exp_w[1], 30); chk("g1_time", t, 19);
    run_game(2, 16'hACE1, 1'b0, le, t);
    chk("g2_expected", exp_w[2], 26); chk("g2_time", t, 28);
    run_game(3, 16'hACE1, 1'b0, le, t);
    chk("g3_expected", exp_w[3], 36); chk("g3_time", t, 45);

    // Abort: dut1 in its second gap, dut3 mid-pulse.
    @(negedge clk); start[3] = 1'b1;
    @(negedge clk); start[3] = 1'b0;
    @(negedge clk); start[1] = 1'b1;
    @(negedge clk); start[1] = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_pre_stop1", stop_w[1], 0);
    chk("abort_pre_stop3", stop_w[3], 1);
    chk("abort_pre_ridx1", ridx_w[1], 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_stop1", stop_w[1], 0); chk("abort_stop3", stop_w[3], 0);
    chk("abort_busy1", busy_w[1], 0); chk("abort_busy3", busy_w[3], 0);
    chk("abort_ridx1", ridx_w[1], 0); chk("abort_ridx3", ridx_w[3], 0);
    dcnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (done_w[1] || done_w[3] || stop_w[1] || stop_w[3]) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);
    run_game(1, 16'hACE1, 1'b0, le, t);
    chk("restart_expected", exp_w[1], 30);

    // Random-gap game with start poked while busy, then seed_load+start.
    run_game(0, 16'hACE1, 1'b1, le, t);
    chk("lfsr_after_game", dut0.lfsr, le);
    run_game(1, 16'hACE1, 1'b1, l0, t);
    chk("poke_expected", exp_w[1], 30);
    @(negedge clk); seed_load = 1'b1; seed = 16'h0000; start[0] = 1'b1;
    @(negedge clk); seed_load = 1'b0; start[0] = 1'b0;
    chk("zero_seed_lfsr", dut0.lfsr, 16'hACE1);
    chk("seed_prio_busy", busy_w[0], 0);
    repeat (3) @(negedge clk);
    chk("seed_prio_ridx", ridx_w[0], 3);
    chk("seed_prio_idle", busy_w[0], 0);

    // Randomly seeded games on the default configuration.
    for (int n = 0; n < 100; n++) begin
      s = 16'($urandom);
      if (n % 10 == 0) s = 16'h0000;
      @(negedge clk); seed_load = 1'b1; seed = s;
      @(negedge clk); seed_load = 1'b0;
      l0 = (s == 16'h0000) ? 16'hACE1 : s;
      chk("seed_lfsr", dut0.lfsr, l0);
      run_game(0, l0, (n % 7 == 0), le, t);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/chance_player.md
Name: chance_player

Overview:
- Player-side stimulus and reference model for the stop/answer game.
- The scorer side free-runs a 4-bit counter while `stop` is low, samples the counter on each `stop` rising edge, and reports the sum after ROUNDS samples.
- This block generates the `stop` pulses at pseudo-random intervals from a 16-bit LFSR. It mirrors the scorer's counter internally and reports the answer the scorer must produce.
- It drives the scorer's `stop` input directly and is used both as on-chip auto-player and as bench driver/checker.

Parameters:
- ROUNDS, 3: stop pulses per game (1..15).
- MIN_GAP, 2: minimum `stop`-low cycles before each pulse (>=1).
- GAP_RAND_BITS, 4: LFSR bits added to the gap (0..8). 0 gives a fixed gap of exactly MIN_GAP.
- PULSE_W, 1: cycles `stop` is held high per pulse (>=1).
- LFSR_SEED, 16'hACE1: reset seed; also substituted for a zero seed.
- CNT_W, 4: mirrored counter width.
- SUM_W, 7: expected-sum width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a game; sampled only in IDLE.
- seed_load  in  1  load `seed` into the LFSR; sampled only in IDLE.
- seed  in  16  LFSR seed value.
- stop  out  1  registered stop line to the scorer.
- busy  out  1  high from the cycle after `start` until `done`.
- done  out  1  one-cycle pulse when the game completes.
- expected  out  SUM_W  predicted answer; valid from `done`, held until the next `start`.
- round_idx  out  4  number of completed pulses in the current game.

Behaviour:

Reset:
- On a clock edge with `reset`=1: state=IDLE; `stop`=0, `busy`=0, `done`=0, `expected`=0, `round_idx`=0.
- Mirror counter m=0, sum=0, LFSR=LFSR_SEED.
- Reset mid-game aborts immediately. `stop` is low in the next cycle and no `done` is issued.

LFSR:
- Fibonacci, x^16+x^14+x^13+x^11+1, shifted left with feedback into bit 0.
- Advances every cycle while `busy`; frozen in IDLE.

Gap computation:
- gap = MIN_GAP + (lfsr & ((1<<GAP_RAND_BITS)-1)).
- Computed on `start` and at the end of each pulse that is not the last.

States:
- IDLE
  - `seed_load`=1: LFSR<=seed, or LFSR_SEED if seed==0. `seed_load` has priority, so a simultaneous `start` is ignored.
  - `start`=1 (and no `seed_load`): m<=0, sum<=0, `round_idx`<=0, `expected`<=0, gap counter<=gap, go to GAP.
  - Both inputs are ignored outside IDLE.
- GAP
  - `stop`=0. Gap counter decrements each cycle.
  - After exactly gap cycles, go to PULSE.
- PULSE
  - `stop`=1 for exactly PULSE_W cycles.
  - At the end of the first PULSE cycle: sum <= sum + m, zero-extended to SUM_W, wrapping mod 2^SUM_W.
  - At the end of the last PULSE cycle: `round_idx`++. If `round_idx` becomes ROUNDS, go to DONE; otherwise reload the gap counter and go to GAP.
- DONE
  - One cycle: `done`=1, `expected`<=sum, `busy`=0 afterwards, go to IDLE.

Mirror counter:
- Each edge while `busy`: m <= `stop` ? m : m+1, wrapping mod 2^CNT_W. This matches the scorer, which increments only while `stop` is low and holds during pulses.

Timing:
- Game length from `start` to `done` = sum over rounds of (gap_i + PULSE_W) + 1 cycles.
- `stop` is never high in IDLE or DONE. Back-to-back pulses are impossible because MIN_GAP>=1.

Decomposition:
- Package chance_pkg holds:
  - state enum {IDLE, GAP, PULSE, DONE};
  - LFSR tap mask 16'hB400;
  - default LFSR_SEED;
  - CNT_W=4 and SUM_W=7 constants, shared with the scorer.
- One sub-module, chance_lfsr16:
  - 16-bit LFSR with load, enable, and zero-seed substitution.
  - Reused by future game blocks.

Test Plan:
- Reset, then idle 10 cycles -> `stop`=0, `busy`=0, `done`=0, `expected`=0, LFSR==16'hACE1.
- GAP_RAND_BITS=0, MIN_GAP=5, PULSE_W=1, ROUNDS=3; `start` -> pulses follow with m=5,10,15; `done` 19 cycles after `start`; `expected`=30.
- GAP_RAND_BITS=0, MIN_GAP=7, ROUNDS=3 -> m=7,14,5 (wrap); `expected`=26. Same with ROUNDS=4, MIN_GAP=10 -> m=10,4,14,8; `expected`=36.
- Assert `reset` during the second GAP -> `stop` low next cycle, no `done`. A new `start` then gives `expected`=30 (config of the second scenario).
- `seed_load` with seed=0, asserted together with `start` -> LFSR=16'hACE1 and no game starts. `start` pulsed while `busy` -> ignored, `round_idx` sequence unchanged.
- Random seeds, default params, scorer instance connected -> scorer answer == `expected` for 100 games; every gap in [2,17].
